// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO built around an external
// SRAM. Accepts producer words with a valid/ready handshake, issues registered
// SRAM writes one edge after acceptance, publishes the committed write pointer
// in Gray code to the reader domain, and synchronizes the reader's Gray pointer
// back to compute free space, full and almost-full.
//
// Ports
//   clk_a        in   1        write-domain clock (rising edge)
//   rst          in   1        asynchronous active-high reset
//   in_valid     in   1        producer word valid
//   in_data      in   WIDTH    producer word
//   in_ready     out  1        controller can accept a word
//   addr_a       out  A        SRAM write address (registered)
//   wdata_a      out  WIDTH    SRAM write data (registered)
//   write_en_a   out  1        SRAM write strobe (registered)
//   wr_ptr_gray  out  A+1      committed write pointer, Gray code
//   rd_ptr_gray  in   A+1      reader pointer, Gray code, asynchronous
//   full         out  1        no free word
//   almost_full  out  1        free_count <= AFULL_THRESH
//   free_count   out  A+1      free words, 0..DEPTH
//   overflow     out  1        sticky: word offered while full
//   ovf_clr      in   1        synchronous clear of overflow
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8192,
  parameter int AFULL_THRESH = 4,
  localparam int A           = $clog2(DEPTH)
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [A-1:0]     addr_a,
  output logic [WIDTH-1:0] wdata_a,
  output logic             write_en_a,
  output logic [A:0]       wr_ptr_gray,
  input  logic [A:0]       rd_ptr_gray,
  output logic             full,
  output logic             almost_full,
  output logic [A:0]       free_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [A:0] DEPTH_P = (A+1)'(DEPTH);
  localparam logic [A:0] ONE_P   = (A+1)'(1);

  logic [A:0] r_wr_bin;
  logic [A:0] r_rd_sync1;
  logic [A:0] r_rd_sync2;

  logic [A:0] w_rd_bin_s;
  logic [A:0] w_used;
  logic [A:0] w_free;
  logic       w_full;
  logic       w_accept;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= A; gi++) begin : g_gray2bin
      assign w_rd_bin_s[gi] = ^r_rd_sync2[A:gi];
    end
  endgenerate

  // Occupancy uses the incremented write pointer immediately, but the reader
  // pointer only after synchronization, so full errs on the safe side.
  assign w_used   = r_wr_bin - w_rd_bin_s;
  assign w_free   = DEPTH_P - w_used;
  assign w_full   = (w_used == DEPTH_P);
  assign w_accept = in_valid && in_ready;

  assign in_ready    = !w_full && !rst;
  assign full        = w_full;
  assign free_count  = w_free;
  assign almost_full = (32'(w_free) <= AFULL_THRESH);

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      r_wr_bin    <= '0;
      r_rd_sync1  <= '0;
      r_rd_sync2  <= '0;
      wr_ptr_gray <= '0;
      write_en_a  <= 1'b0;
      addr_a      <= '0;
      wdata_a     <= '0;
      overflow    <= 1'b0;
    end else begin
      r_rd_sync1 <= rd_ptr_gray;
      r_rd_sync2 <= r_rd_sync1;

      // Encoded from the pre-increment pointer: the published pointer moves on
      // the same edge the SRAM write lands, so the reader never sees a word
      // before it exists in memory.
      wr_ptr_gray <= r_wr_bin ^ (r_wr_bin >> 1);

      write_en_a <= w_accept;
      if (w_accept) begin
        addr_a   <= r_wr_bin[A-1:0];
        wdata_a  <= in_data;
        r_wr_bin <= r_wr_bin + ONE_P;
      end

      // Set has priority over clear so a simultaneous event is never lost.
      if (in_valid && w_full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AFT   = 2;
  localparam int A     = 3;

  logic             clk_a = 1'b0;
  logic             rst   = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_ready;
  logic [A-1:0]     addr_a;
  logic [WIDTH-1:0] wdata_a;
  logic             write_en_a;
  logic [A:0]       wr_ptr_gray;
  logic [A:0]       rd_ptr_gray = '0;
  logic             full;
  logic             almost_full;
  logic [A:0]       free_count;
  logic             overflow;
  logic             ovf_clr = 1'b0;

  fifo_wr_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk_a(clk_a),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .addr_a(addr_a),
    .wdata_a(wdata_a),
    .write_en_a(write_en_a),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .full(full),
    .almost_full(almost_full),
    .free_count(free_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 clk_a = ~clk_a;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [A-1:0]     addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;

  // Reference model: plain counts of words accepted / written / read.
  int m_wr;       // words accepted since reset
  int m_written;  // words whose SRAM write has been committed
  int m_rd;       // reader count currently driven
  int m_rd_d1;    // reader count driven one edge ago
  int m_rd_vis;   // reader count the writer side is allowed to see
  bit m_ovf;

  function automatic logic [A:0] gray(input int n);
    logic [A:0] b;
    b = n[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every SRAM write strobe must match the oldest expected write.
  always @(negedge clk_a) begin
    if (!rst && write_en_a) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr=%0d data=0x%04h expected none at %0t",
                 addr_a, wdata_a, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("addr_a", 32'(addr_a), 32'(mon_e.addr));
        chk("wdata_a", 32'(wdata_a), 32'(mon_e.data));
        $display("write addr=%0d data=0x%04h", addr_a, wdata_a);
      end
    end
  end

  // One clock cycle: drive at the falling edge, predict, step the model at
  // the rising edge, then compare status outputs at the next falling edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit clr, input int rd_new);
    int  used;
    bit  exp_full;
    bit  acc;
    wr_t e;
    in_valid    = v;
    in_data     = d;
    ovf_clr     = clr;
    rd_ptr_gray = gray(rd_new);
    used     = m_wr - m_rd_vis;
    exp_full = (used == DEPTH);
    acc      = v && !exp_full;
    if (acc) begin
      e.addr = 3'(m_wr % DEPTH);
      e.data = d;
      sb_q.push_back(e);
    end
    @(posedge clk_a);
    if (v && exp_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_written = m_wr;
    if (acc) m_wr++;
    m_rd_vis = m_rd_d1;
    m_rd_d1  = rd_new;
    m_rd     = rd_new;
    @(negedge clk_a);
    used = m_wr - m_rd_vis;
    chk("free_count", 32'(free_count), 32'(DEPTH - used));
    chk("full", 32'(full), 32'(used == DEPTH));
    chk("almost_full", 32'(almost_full), 32'((DEPTH - used) <= AFT));
    chk("in_ready", 32'(in_ready), 32'(used != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray(m_written)));
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    ovf_clr     = 1'b0;
    rd_ptr_gray = '0;
    #1;
    chk("rst_write_en", 32'(write_en_a), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    @(negedge clk_a);
    @(negedge clk_a);
    chk("rst_addr_a", 32'(addr_a), 32'(0));
    chk("rst_wdata_a", 32'(wdata_a), 32'(0));
    rst = 1'b0;
    sb_q.delete();
    m_wr = 0; m_written = 0; m_rd = 0; m_rd_d1 = 0; m_rd_vis = 0; m_ovf = 1'b0;
    #1;
    chk("post_rst_free", 32'(free_count), 32'(DEPTH));
    chk("post_rst_full", 32'(full), 32'(0));
    chk("post_rst_afull", 32'(almost_full), 32'(0));
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    $display("reset done");
  endtask

  task automatic random_phase(input int n);
    int rn;
    for (int i = 0; i < n; i++) begin
      rn = m_rd;
      if ($urandom_range(0, 2) == 0 && m_written > m_rd)
        rn = m_rd + int'($urandom_range(1, 32'(m_written - m_rd)));
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 15) == 0, rn);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Fill from empty, reader parked at 0.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0, 0);
    cycle(1'b1, 16'hA0FF, 1'b0, 0);   // offered while full -> overflow
    cycle(1'b0, '0, 1'b0, 0);
    cycle(1'b1, 16'hA0EE, 1'b1, 0);   // set and clear together: stays set
    cycle(1'b0, '0, 1'b1, 0);         // clear alone

    // Reader jumps to 3: visible only after two edges.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 3);

    // Wrap: reader follows the committed writer pointer.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'(16'hB000 + i), 1'b0, m_written);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, m_written);

    // Randomized traffic with reader advances.
    do_reset();
    random_phase(400);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, m_rd);

    // Reset arriving while a write is in flight.
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    ovf_clr  = 1'b0;
    @(posedge clk_a);
    #1;
    chk("inflight_write_en", 32'(write_en_a), 32'(1));
    rst = 1'b1;
    #1;
    chk("midrst_write_en", 32'(write_en_a), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    do_reset();
    random_phase(60);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, m_rd);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 8192, FIFO storage depth in words (power of two, >=4).
REQ-003 SHALL have parameter AFULL_THRESH, default 4, free-word level at or below which almost_full asserts.
REQ-004 SHALL derive localparam A = $clog2(DEPTH); pointers are A+1 bits.
REQ-005 SHALL have port: clk_a  input  1  write-domain clock (rising edge).
REQ-006 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: in_valid  input  1  producer word valid.
REQ-008 SHALL have port: in_data  input  WIDTH  producer word.
REQ-009 SHALL have port: in_ready  output  1  controller can accept a word.
REQ-010 SHALL have port: addr_a  output  A  SRAM write address.
REQ-011 SHALL have port: wdata_a  output  WIDTH  SRAM write data.
REQ-012 SHALL have port: write_en_a  output  1  SRAM write strobe.
REQ-013 SHALL have port: wr_ptr_gray  output  A+1  committed write pointer, Gray code, to reader domain.
REQ-014 SHALL have port: rd_ptr_gray  input  A+1  reader pointer, Gray code, asynchronous to clk_a.
REQ-015 SHALL have port: full  output  1  no free word.
REQ-016 SHALL have port: almost_full  output  1  free_count <= AFULL_THRESH.
REQ-017 SHALL have port: free_count  output  A+1  free words, 0..DEPTH.
REQ-018 SHALL have port: overflow  output  1  sticky: word offered while full.
REQ-019 SHALL have port: ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-020 SHALL accept a word at a clk_a edge iff in_valid && in_ready; in_ready = !full && !rst.
REQ-021 On accept: write_en_a<=1, addr_a<=wr_bin[A-1:0], wdata_a<=in_data, wr_bin<=wr_bin+1 (same edge); no accept: write_en_a<=0, addr_a/wdata_a hold.
REQ-022 Latency: word on in_data at accept edge E written into SRAM at edge E+1.
REQ-023 wr_ptr_gray SHALL be a register loaded every edge with wr_bin ^ (wr_bin>>1), so it advances on the same edge the SRAM write occurs, never earlier.
REQ-024 rd_ptr_gray SHALL pass a 2-flop synchronizer (both flops reset to 0) and be converted Gray->binary as rd_bin_s.
REQ-025 used = (wr_bin - rd_bin_s) mod 2^(A+1); free_count = DEPTH - used; full = (used == DEPTH); all combinational from registers.
REQ-026 Pointers wrap modulo 2*DEPTH; addr_a wraps DEPTH-1 -> 0 with no gap or stall.
REQ-027 overflow SHALL set at an edge where in_valid && full; cleared at an edge where ovf_clr=1; simultaneous set and clear -> set wins; rejected word SHALL NOT be written and SHALL NOT move pointers.
REQ-028 Reader pointer advance SHALL reduce used no earlier than 2 edges after rd_ptr_gray changes; full is therefore pessimistic, never optimistic.
REQ-029 Accept and reader advance in same cycle SHALL both take effect (free_count net change = reader delta - 1).

Reset
REQ-030 While rst=1 (asynchronously): wr_bin=0, wr_ptr_gray=0, sync flops=0, write_en_a=0, addr_a=0, wdata_a=0, overflow=0, in_ready=0.
REQ-031 After rst deasserts: full=0, almost_full=(DEPTH<=AFULL_THRESH), free_count=DEPTH, in_ready=1.
REQ-032 rst asserted mid-write SHALL drop write_en_a immediately; the in-flight word is discarded.

Verification (DEPTH=8, WIDTH=16, AFULL_THRESH=2)
REQ-033 Reset: pulse rst -> free_count=8, full=0, write_en_a=0, wr_ptr_gray=4'b0000, in_ready=1.
REQ-034 Fill: rd_ptr_gray=0, 8 back-to-back words 0xA000..0xA007 -> addr_a 0..7 one edge after each accept, full=1 and in_ready=0 after 8th accept; 9th offer -> overflow=1, no write_en_a.
REQ-035 Almost full: after 6 accepts -> free_count=2, almost_full=1; after 5 -> almost_full=0.
REQ-036 Drain sync: from full, drive rd_ptr_gray=4'b0010 (bin 3) -> free_count stays 0 for 1 edge, =3 after 2nd edge, full=0.
REQ-037 Wrap: reader tracks writer, 20 accepts -> addr_a sequence 0..7,0..7,0..3; wr_ptr_gray=4'b1100 when wr_bin=8; no overflow.
REQ-038 Overflow clear: overflow=1, ovf_clr=1 with in_valid&&full same edge -> overflow stays 1; ovf_clr alone next edge -> 0.
